// File: rtl/tc_pl_bus_tx_spit.sv
// SPI mode-0 transmit engine fed by the bus TX framer: byte handshake via spit_dreq,
// MSB-first serialisation, back-to-back bytes merged into one CS-low frame.
module tc_pl_bus_tx_spit #(
    parameter int SPI0_0   = 8,
    parameter int CLK_DIV  = 2,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spit_valid,
    input  logic [SPI0_0-1:0] spit_data,
    output logic              spit_dreq,
    output logic              spit_idle,
    output logic              spi_cs_n,
    output logic              spi_sclk,
    output logic              spi_mosi
);
    localparam int CNT_M1  = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
    localparam int CNT_MAX = (CNT_M1 > CS_HOLD) ? CNT_M1 : CS_HOLD;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int BW      = $clog2(SPI0_0);

    localparam logic [CW-1:0] DIV_LAST   = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(CS_HOLD - 1);
    localparam logic [BW-1:0] BIT_LAST   = BW'(SPI0_0 - 1);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [BW-1:0]     bit_cnt;
    // MSB goes straight to spi_mosi on load, so only the remaining bits are kept
    logic [SPI0_0-2:0] shreg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            spit_dreq <= 1'b0;
            spit_idle <= 1'b1;
            spi_cs_n  <= 1'b1;
            spi_sclk  <= 1'b0;
            spi_mosi  <= 1'b0;
        end else begin
            spit_dreq <= 1'b0;
            case (state)
                IDLE: begin
                    if (spit_valid) begin
                        shreg     <= spit_data[SPI0_0-2:0];
                        spi_mosi  <= spit_data[SPI0_0-1];
                        spit_dreq <= 1'b1;
                        spi_cs_n  <= 1'b0;
                        spit_idle <= 1'b0;
                        cnt       <= '0;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt == SETUP_LAST) begin
                        cnt     <= '0;
                        bit_cnt <= '0;
                        state   <= SHIFT;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                SHIFT: begin
                    if (cnt != DIV_LAST) begin
                        cnt <= cnt + CW'(1);
                    end else begin
                        cnt      <= '0;
                        spi_sclk <= ~spi_sclk;
                        // falling edge: advance the bit, or chain/close the byte
                        if (spi_sclk) begin
                            if (bit_cnt != BIT_LAST) begin
                                bit_cnt  <= bit_cnt + BW'(1);
                                shreg    <= shreg << 1;
                                spi_mosi <= shreg[SPI0_0-2];
                            end else if (spit_valid) begin
                                bit_cnt   <= '0;
                                shreg     <= spit_data[SPI0_0-2:0];
                                spi_mosi  <= spit_data[SPI0_0-1];
                                spit_dreq <= 1'b1;
                            end else begin
                                state <= HOLD;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        cnt       <= '0;
                        spi_cs_n  <= 1'b1;
                        spit_idle <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tc_pl_bus_tx_spit.sv
// Scoreboard bench: two engines (8-bit/div2 and 9-bit/div1); a negedge monitor rebuilds
// bytes from MOSI on SCLK rises and measures CS frames, stimulus pushes expected bytes.
module tb_tc_pl_bus_tx_spit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [1:0] v;
    logic [7:0] d0;
    logic [8:0] d1;
    logic dreq0, idle0, cs0, sclk0, mosi0;
    logic dreq1, idle1, cs1, sclk1, mosi1;

    wire [1:0] dreq = {dreq1, dreq0};
    wire [1:0] idle = {idle1, idle0};
    wire [1:0] cs   = {cs1, cs0};
    wire [1:0] sclk = {sclk1, sclk0};
    wire [1:0] mosi = {mosi1, mosi0};

    tc_pl_bus_tx_spit u_dut0 (
        .clk(clk), .rst(rst), .spit_valid(v[0]), .spit_data(d0),
        .spit_dreq(dreq0), .spit_idle(idle0), .spi_cs_n(cs0), .spi_sclk(sclk0), .spi_mosi(mosi0)
    );

    tc_pl_bus_tx_spit #(.SPI0_0(9), .CLK_DIV(1), .CS_SETUP(2), .CS_HOLD(2)) u_dut1 (
        .clk(clk), .rst(rst), .spit_valid(v[1]), .spit_data(d1),
        .spit_dreq(dreq1), .spit_idle(idle1), .spi_cs_n(cs1), .spi_sclk(sclk1), .spi_mosi(mosi1)
    );

    int n_chk = 0;
    int n_fail = 0;
    logic [15:0] q0[$];
    logic [15:0] q1[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: event did not occur within its cycle budget", name);
    endtask

    // monitor state, one slot per engine
    int nbits[2]   = '{default: 0};
    int pulses[2]  = '{default: 0};
    int cslow[2]   = '{default: 0};
    int cshigh[2]  = '{default: 0};
    int flen[2]    = '{default: 0};
    int fpulses[2] = '{default: 0};
    int gap[2]     = '{default: 0};
    int frames[2]  = '{default: 0};
    int dreqs[2]   = '{default: 0};
    int dbl[2]     = '{default: 0};
    int m0viol[2]  = '{default: 0};
    logic [15:0] sh[2];
    logic [1:0] sclk_p, cs_p, mosi_p, dreq_p;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst) begin
                nbits[i] = 0; pulses[i] = 0; cslow[i] = 0; cshigh[i] = 0; sh[i] = '0;
                sclk_p[i] = 1'b0; cs_p[i] = 1'b1; mosi_p[i] = 1'b0; dreq_p[i] = 1'b0;
            end else begin
                if (dreq[i]) begin
                    dreqs[i]++;
                    if (dreq_p[i]) dbl[i]++;
                end
                if (sclk[i] && sclk_p[i] && (mosi[i] != mosi_p[i])) m0viol[i]++;
                if (sclk[i] && !sclk_p[i]) begin
                    pulses[i]++;
                    sh[i] = {sh[i][14:0], mosi[i]};
                    nbits[i]++;
                    if (nbits[i] == ((i == 0) ? 8 : 9)) begin
                        if (i == 0) begin
                            if (q0.size() == 0) begin
                                n_chk++; n_fail++;
                                $display("FAIL byte0_unexpected: got 0x%0h, want none", sh[i]);
                            end else check("byte0", 32'(sh[i]), 32'(q0.pop_front()));
                        end else begin
                            if (q1.size() == 0) begin
                                n_chk++; n_fail++;
                                $display("FAIL byte1_unexpected: got 0x%0h, want none", sh[i]);
                            end else check("byte1", 32'(sh[i]), 32'(q1.pop_front()));
                        end
                        nbits[i] = 0;
                        sh[i] = '0;
                    end
                end
                if (!cs[i]) begin
                    if (cs_p[i]) begin gap[i] = cshigh[i]; cslow[i] = 1; end
                    else cslow[i]++;
                end else begin
                    if (!cs_p[i]) begin
                        flen[i] = cslow[i]; fpulses[i] = pulses[i]; frames[i]++;
                        pulses[i] = 0; cshigh[i] = 1;
                    end else cshigh[i]++;
                end
                sclk_p[i] = sclk[i]; cs_p[i] = cs[i]; mosi_p[i] = mosi[i]; dreq_p[i] = dreq[i];
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_dreq(input int i, input int lim, output int cyc);
        cyc = 0;
        do begin tick(); cyc++; end while (!dreq[i] && cyc < lim);
        if (!dreq[i]) fail_now($sformatf("dreq%0d_wait", i));
    endtask

    task automatic wait_idle(input int i, input int lim);
        int k = 0;
        do begin tick(); k++; end while (!idle[i] && k < lim);
        if (!idle[i]) fail_now($sformatf("idle%0d_wait", i));
    endtask

    // offer a byte, hold valid until dreq, then drop it and scramble the data bus
    task automatic send(input int i, input logic [8:0] b, input bit expect_byte, output int lat);
        v[i] = 1'b1;
        if (i == 0) begin
            d0 = b[7:0];
            if (expect_byte) q0.push_back(16'(b[7:0]));
        end else begin
            d1 = b;
            if (expect_byte) q1.push_back(16'(b));
        end
        wait_dreq(i, 80, lat);
        v[i] = 1'b0;
        if (i == 0) d0 = ~d0; else d1 = ~d1;
    endtask

    task automatic check_rst_outs(input string tag);
        check({tag, "_cs0"},   32'(cs0),   32'd1);
        check({tag, "_sclk0"}, 32'(sclk0), 32'd0);
        check({tag, "_mosi0"}, 32'(mosi0), 32'd0);
        check({tag, "_dreq0"}, 32'(dreq0), 32'd0);
        check({tag, "_idle0"}, 32'(idle0), 32'd1);
        check({tag, "_cs1"},   32'(cs1),   32'd1);
        check({tag, "_idle1"}, 32'(idle1), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int k;
        rst = 1'b0; v = 2'b00; d0 = '0; d1 = '0;
        repeat (3) tick();
        check_rst_outs("rst_hold");
        rst = 1'b1;
        repeat (3) tick();
        check_rst_outs("rst_rel");

        // single byte, default timing: 2 setup + 32 shift + 2 hold
        send(0, 9'h0A5, 1'b1, lat);
        check("a5_lat", 32'(lat), 32'd1);
        check("a5_idle_low", 32'(idle0), 32'd0);
        check("a5_cs_low", 32'(cs0), 32'd0);
        wait_idle(0, 200);
        check("a5_cs_high", 32'(cs0), 32'd1);
        check("a5_flen", 32'(flen[0]), 32'd36);
        check("a5_pulses", 32'(fpulses[0]), 32'd8);
        repeat (2) tick();

        // back-to-back: one frame, second byte taken on the 8th falling edge
        send(0, 9'h03C, 1'b1, lat);
        tick();
        send(0, 9'h0C3, 1'b1, lat);
        check("b2b_lat2", 32'(lat), 32'd33);
        wait_idle(0, 200);
        check("b2b_flen", 32'(flen[0]), 32'd68);
        check("b2b_pulses", 32'(fpulses[0]), 32'd16);
        repeat (2) tick();

        // valid arriving in HOLD waits for IDLE: exactly one CS-high cycle
        send(0, 9'h05A, 1'b1, lat);
        repeat (34) tick();
        check("hold_cs", 32'(cs0), 32'd0);
        check("hold_sclk", 32'(sclk0), 32'd0);
        send(0, 9'h096, 1'b1, lat);
        check("hold_lat", 32'(lat), 32'd3);
        check("hold_flen1", 32'(flen[0]), 32'd36);
        check("hold_gap", 32'(gap[0]), 32'd1);
        wait_idle(0, 200);
        check("hold_flen2", 32'(flen[0]), 32'd36);
        repeat (2) tick();

        // reset after 3 SCLK pulses drops the partial byte
        send(0, 9'h0F0, 1'b0, lat);
        k = 0;
        while (pulses[0] < 3 && k < 100) begin tick(); k++; end
        if (pulses[0] != 3) fail_now("midrst_pulses");
        check("midrst_sclk_before", 32'(sclk0), 32'd1);
        rst = 1'b0;
        #1;
        check_rst_outs("midrst");
        tick(); tick();
        rst = 1'b1;
        tick();
        send(0, 9'h081, 1'b1, lat);
        check("post_rst_lat", 32'(lat), 32'd1);
        wait_idle(0, 200);
        check("post_rst_flen", 32'(flen[0]), 32'd36);
        check("post_rst_pulses", 32'(fpulses[0]), 32'd8);

        // 9-bit engine, CLK_DIV=1: 2 setup + 18 shift + 2 hold
        send(1, 9'h1FF, 1'b1, lat);
        check("w9_lat", 32'(lat), 32'd1);
        wait_idle(1, 100);
        check("w9_flen", 32'(flen[1]), 32'd22);
        check("w9_pulses", 32'(fpulses[1]), 32'd9);
        tick();
        send(1, 9'h155, 1'b1, lat);
        wait_idle(1, 100);
        check("w9b_flen", 32'(flen[1]), 32'd22);
        repeat (3) tick();

        check("q0_left", 32'(q0.size()), 32'd0);
        check("q1_left", 32'(q1.size()), 32'd0);
        check("dreq0_total", 32'(dreqs[0]), 32'd7);
        check("dreq1_total", 32'(dreqs[1]), 32'd2);
        check("dreq_multi_cycle", 32'(dbl[0] + dbl[1]), 32'd0);
        check("mosi_change_sclk_high", 32'(m0viol[0] + m0viol[1]), 32'd0);
        check("frames0", 32'(frames[0]), 32'd5);
        check("frames1", 32'(frames[1]), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
